ctrl_input_sched: RTL and testbench
===================================

// Module: ctrl_input_sched
// PURPOSE
// - Scripted joypad input scheduler + dual serial pad port for NES sim/bring-up.
// - Replays a frame-indexed button table into both controller ports, starting at a
//   given vblank count.
// - Implements the NES $4016/$4017 latch/shift protocol toward the CPU bus
//   (strobe/rd -> data).
// - Sits between u_nes (ctrl_strobe/ctrl_rd/ctrl_data) and the frame counter
//   (vblank); replaces fixed btns.
// PARAMETERS
// DEPTH      64      table entries (power of 2)
// INIT_FILE  ""      $readmemh image; entry = {frame[15:0], btns1[7:0], btns0[7:0]}
// END_FRAME  16'hFFFF  frame field value marking end of script
// PORTS
// clk        in   1   CPU clock
// rst_n      in   1   async active-low reset
// en         in   1   1 = scheduler advances; 0 = freeze table pointer, pads keep current btns
// vblank     in   1   PPU vblank level, synchronous to clk; rising edge = new frame
// strobe     in   1   $4016 write bit0 (shared latch for both pads)
// rd         in   2   per-port read strobe (bit0 = $4016, bit1 = $4017)
// data       out  2   serial pad bit per port, 1 = pressed
// btns0      out  8   current pad0 buttons (A,B,Sel,Start,U,D,L,R = bit0..7)
// btns1      out  8   current pad1 buttons
// frame_cnt  out 16   vblank rising edges seen since reset (saturates at 16'hFFFE)
// done       out  1   END_FRAME entry reached
// BEHAVIOUR
// - Reset values: btns0 = btns1 = 0, frame_cnt = 0, done = 0, data = 2'b00,
//   FSM = FETCH, ptr = 0, shift regs = 0, counters = 0.
// - Table ROM: registered read, 1-cycle latency. ptr is DEPTH-log2 wide; ptr wrap
//   past DEPTH-1 -> done = 1 (treated as END).
// - Frame count: vblank_q & ~vblank_d increments frame_cnt, saturating at 16'hFFFE.
// - FSM:
//   - FETCH: issue read at ptr -> LOAD.
//   - LOAD: capture entry.
//     - frame == END_FRAME -> DONE.
//     - else -> WAIT.
//   - WAIT: when en && entry.frame <= frame_cnt -> APPLY. Covers late/missed
//     entries (applied immediately) and the same-cycle vblank edge (uses the
//     updated count).
//   - APPLY: btns0/btns1 <= entry, ptr++ -> FETCH. Two equal-frame entries both
//     apply; last wins within that frame.
//   - DONE: done = 1; btns hold last values; stays until reset.
//   - en = 0 holds FSM in WAIT/FETCH; vblank still counted.
// - Pad port, per port p, identical logic:
//   - strobe = 1: sr[p] <= btns_p every cycle, cnt[p] <= 0, data[p] = btns_p[0]
//     (live A button).
//   - strobe = 0: data[p] = sr[p][0]. Read completes on rd[p] falling edge
//     (rd_q & ~rd): sr >>= 1 with MSB fill 1, cnt++ saturating at 8.
//   - After 8 reads data[p] = 1 for all further reads until the next strobe.
//   - rd falling edge in the same cycle as strobe = 1: reload wins, no shift.
//   - btns change while strobe = 0: does not affect sr (latched snapshot).
//     Takes effect at the next strobe.
//   - Reads of port 0 never disturb port 1, and vice versa.
// - Async reset mid-frame or mid-shift: all state cleared immediately. Script
//   restarts at entry 0 after release.
// STRUCTURE
// - Package ctrl_pkg:
//   - typedef struct packed {logic [15:0] frame; logic [7:0] btns1, btns0;} sched_entry_t;
//   - typedef enum {FETCH, LOAD, WAIT, APPLY, DONE} sched_state_t;
//   - localparam BTN_A..BTN_RIGHT bit indices.
// - Sub-module pad_shift_port (one instance per port): strobe, rd, btns -> data.
// - Top holds ROM, FSM, frame counter.
// TESTING
// - Table {0005:00:04, 0007:80:01, FFFF}; pulse vblank x8.
//   -> btns0 = 0 until frame 5, then 8'h04.
//   -> At frame 7: btns0 = 8'h01, btns1 = 8'h80.
//   -> done = 1 after the FFFF fetch, frame_cnt = 8.
// - btns0 = 8'h05; strobe 1 -> 0; 10 rd[0] pulses.
//   -> data[0] sequence 1,0,1,0,0,0,0,0,1,1.
//   -> data[1] unchanged by the rd[0] pulses.
// - Entry frame 3, en = 0 through frames 0..6, then en = 1.
//   -> apply in the cycle after en rises; frame_cnt = 7 continues.
// - Change btns mid-read (after 3 rd pulses).
//   -> remaining bits come from the old snapshot.
//   -> next strobe loads the new value.
// - rd falling edge coincident with strobe = 1 -> no shift, cnt = 0,
//   data = btns[0].
// - Assert rst_n low mid-shift and after frame 4 -> outputs = reset values
//   within the same cycle; script replays from entry 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared types and constants for the scripted joypad scheduler.
// - sched_entry_t : one script table entry {frame, btns1, btns0}
// - sched_state_t : scheduler FSM states
// - BTN_*         : bit positions of each button inside a pad byte
// - sat_inc       : frame counter increment that saturates at FRAME_SAT
package ctrl_pkg;

    typedef struct packed {
        logic [15:0] frame;
        logic [7:0]  btns1;
        logic [7:0]  btns0;
    } sched_entry_t;

    localparam int ENTRY_W = $bits(sched_entry_t);

    typedef enum logic [2:0] {
        FETCH,
        LOAD,
        WAIT,
        APPLY,
        DONE
    } sched_state_t;

    // Button bit order, matching the order the pad shifts them out.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Number of button reads before the pad starts returning constant 1s.
    localparam logic [3:0] PAD_READS = 4'd8;

    // 16'hFFFF is reserved as the end-of-script marker, so the count stops one short.
    localparam logic [15:0] FRAME_SAT = 16'hFFFE;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == FRAME_SAT) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pad_shift_port.sv
// pad_shift_port
// One NES controller port: the 4016/4017 latch-and-shift protocol.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   strobe     : shared latch bit; while high the shift register tracks btns
//   rd         : read strobe for this port; a read completes on its falling edge
//   btns       : current button byte (A..Right = bit0..7)
//   data       : serial button bit presented to the CPU, 1 = pressed
module pad_shift_port
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe,
    input  logic       rd,
    input  logic [7:0] btns,
    output logic       data
);

    logic [7:0] sr;
    logic [3:0] cnt;
    logic       rd_q;
    logic       rd_fall;

    assign rd_fall = rd_q & ~rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd;
        end
    end

    // Strobe takes priority over a completing read, so a read that ends
    // while the latch is open is absorbed by the reload rather than shifting.
    // Shifting fills from the top with 1s, which is what real pads return
    // once all eight buttons have been read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= 8'h00;
            cnt <= 4'd0;
        end else if (strobe) begin
            sr  <= btns;
            cnt <= 4'd0;
        end else if (rd_fall) begin
            sr  <= {1'b1, sr[BTN_RIGHT:BTN_B]};
            cnt <= (cnt == PAD_READS) ? cnt : cnt + 4'd1;
        end
    end

    // While latched the pad shows the live A button, not the stored snapshot.
    always_comb begin
        data = sr[BTN_A];
        if (strobe) begin
            data = btns[BTN_A];
        end else if (cnt == PAD_READS) begin
            data = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_input_sched.sv
// ctrl_input_sched
// Scripted joypad input scheduler plus the two serial pad ports.
// A table of {frame, btns1, btns0} entries is replayed into both pads,
// each entry taking effect once the vblank count reaches its frame.
// Parameters:
//   DEPTH     : table entries (power of 2, at least 2)
//   END_FRAME : frame value marking the end of the script
//   INIT_DATA : table image, entry i at bits [i*32 +: 32]
// Ports:
//   clk, rst_n : CPU clock, async active-low reset
//   en         : 1 = scheduler may apply entries, 0 = hold in WAIT
//   vblank     : PPU vblank level; rising edge starts a new frame
//   strobe     : shared pad latch ($4016 bit0)
//   rd[1:0]    : per-port read strobes ($4016, $4017)
//   data[1:0]  : per-port serial button bit, 1 = pressed
//   btns0/1    : buttons currently presented to each pad
//   frame_cnt  : vblank rising edges since reset, saturating at 16'hFFFE
//   done       : end of script reached
module ctrl_input_sched
    import ctrl_pkg::*;
#(
    parameter int                       DEPTH     = 64,
    parameter logic [15:0]              END_FRAME = 16'hFFFF,
    parameter logic [DEPTH*ENTRY_W-1:0] INIT_DATA = {DEPTH{END_FRAME, 16'h0000}}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        vblank,
    input  logic        strobe,
    input  logic [1:0]  rd,
    output logic [1:0]  data,
    output logic [7:0]  btns0,
    output logic [7:0]  btns1,
    output logic [15:0] frame_cnt,
    output logic        done
);

    localparam int PTR_W = $clog2(DEPTH);

    sched_state_t state;
    sched_state_t state_nxt;

    sched_entry_t rom [DEPTH];
    sched_entry_t rom_q;
    sched_entry_t entry_q;
    logic [PTR_W-1:0] ptr;

    logic        vblank_q;
    logic        vblank_d;
    logic        vblank_rise;
    logic [15:0] frame_cnt_nxt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = INIT_DATA[i*ENTRY_W +: ENTRY_W];
    end

    // The table is read every cycle at ptr; FETCH exists only to give this
    // registered read its one cycle before LOAD looks at rom_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_q <= '0;
        end else begin
            rom_q <= rom[ptr];
        end
    end

    assign vblank_rise   = vblank_q & ~vblank_d;
    assign frame_cnt_nxt = vblank_rise ? sat_inc(frame_cnt) : frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q  <= 1'b0;
            vblank_d  <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            vblank_q  <= vblank;
            vblank_d  <= vblank_q;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    // WAIT compares against the count as it will be after this edge, so an
    // entry due on the frame that is starting right now is not held back a
    // cycle. Using <= rather than == lets late entries (en was low, or two
    // entries share a frame) apply as soon as the FSM reaches them.
    // Wrapping ptr past the last entry is treated as an end marker.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = (rom_q.frame == END_FRAME) ? DONE : WAIT;
            WAIT: begin
                if (en && (entry_q.frame <= frame_cnt_nxt)) begin
                    state_nxt = APPLY;
                end
            end
            APPLY: state_nxt = (ptr == PTR_W'(DEPTH - 1)) ? DONE : FETCH;
            DONE:  state_nxt = DONE;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            ptr     <= '0;
            btns0   <= 8'h00;
            btns1   <= 8'h00;
        end else begin
            if (state == LOAD) begin
                entry_q <= rom_q;
            end
            if (state == APPLY) begin
                btns0 <= entry_q.btns0;
                btns1 <= entry_q.btns1;
                ptr   <= ptr + 1'b1;
            end
        end
    end

    assign done = (state == DONE);

    pad_shift_port u_pad0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (strobe),
        .rd     (rd[0]),
        .btns   (btns0),
        .data   (data[0])
    );

    pad_shift_port u_pad1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (strobe),
        .rd     (rd[1]),
        .btns   (btns1),
        .data   (data[1])
    );

endmodule

// File: tb/tb_ctrl_input_sched.sv
// tb_ctrl_input_sched
// Directed bench for ctrl_input_sched with a four-entry script:
//   frame 5 -> btns1 00 / btns0 04
//   frame 7 -> btns1 80 / btns0 01
//   frame 8 -> btns1 3C / btns0 05
//   end marker
module tb_ctrl_input_sched;

    localparam int DEPTH = 8;
    localparam logic [DEPTH*32-1:0] SCRIPT = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
        32'hFFFF_0000, 32'h0008_3C05, 32'h0007_8001, 32'h0005_0004
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        vblank = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  rd = 2'b00;
    logic [1:0]  data;
    logic [7:0]  btns0;
    logic [7:0]  btns1;
    logic [15:0] frame_cnt;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic       bit_val;
    logic [1:0] live;
    logic [7:0] snapshot;
    logic [9:0] seq05;

    always #5 clk = ~clk;

    ctrl_input_sched #(
        .DEPTH     (DEPTH),
        .END_FRAME (16'hFFFF),
        .INIT_DATA (SCRIPT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .vblank    (vblank),
        .strobe    (strobe),
        .rd        (rd),
        .data      (data),
        .btns0     (btns0),
        .btns1     (btns1),
        .frame_cnt (frame_cnt),
        .done      (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with
    // the frame counted and any entry due on it already applied.
    task automatic applyStimulus();
        vblank = 1'b1;
        repeat (2) @(posedge clk);
        #1 vblank = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Opens the latch for one cycle and reports the live data bits seen meanwhile.
    task automatic latchPads(output logic [1:0] live_bits);
        strobe = 1'b1;
        @(negedge clk);
        live_bits = data;
        @(posedge clk);
        #1 strobe = 1'b0;
    endtask

    // One complete read on a port; returns the bit presented before the shift.
    task automatic readBit(input int port, output logic b);
        rd[port] = 1'b1;
        @(negedge clk);
        b = data[port];
        @(posedge clk);
        #1 rd[port] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        seq05 = 10'b11_0000_0101;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_btns0", 32'(btns0), 32'h00);
        checkOutput("reset_btns1", 32'(btns1), 32'h00);
        checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_data", 32'(data), 32'd0);

        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] script replay");
        for (int f = 1; f <= 4; f++) begin
            applyStimulus();
            checkOutput("pre_frame5_btns0", 32'(btns0), 32'h00);
        end
        checkOutput("frame4_cnt", 32'(frame_cnt), 32'd4);
        applyStimulus();
        checkOutput("frame5_btns0", 32'(btns0), 32'h04);
        checkOutput("frame5_btns1", 32'(btns1), 32'h00);
        checkOutput("frame5_cnt", 32'(frame_cnt), 32'd5);
        applyStimulus();
        checkOutput("frame6_btns0", 32'(btns0), 32'h04);
        applyStimulus();
        checkOutput("frame7_btns0", 32'(btns0), 32'h01);
        checkOutput("frame7_btns1", 32'(btns1), 32'h80);
        checkOutput("frame7_done", 32'(done), 32'd0);

        $display("[TB] buttons change mid-read on port 1");
        latchPads(live);
        checkOutput("latch_live_f7", 32'(live), 32'b01);
        snapshot = 8'h80;
        for (int k = 0; k < 3; k++) begin
            readBit(1, bit_val);
            checkOutput("p1_old_bit_early", 32'(bit_val), 32'(snapshot[k]));
        end
        applyStimulus();
        checkOutput("frame8_btns1", 32'(btns1), 32'h3C);
        checkOutput("frame8_btns0", 32'(btns0), 32'h05);
        for (int k = 3; k < 8; k++) begin
            readBit(1, bit_val);
            checkOutput("p1_old_bit_late", 32'(bit_val), 32'(snapshot[k]));
        end
        readBit(1, bit_val);
        checkOutput("p1_after8", 32'(bit_val), 32'd1);
        checkOutput("p0_untouched", 32'(data[0]), 32'd1);
        checkOutput("frame8_done", 32'(done), 32'd1);
        checkOutput("frame8_cnt", 32'(frame_cnt), 32'd8);

        $display("[TB] port 0 reads of 8'h05");
        latchPads(live);
        checkOutput("latch_live_f8", 32'(live), 32'b01);
        for (int k = 0; k < 10; k++) begin
            readBit(0, bit_val);
            checkOutput("p0_seq05", 32'(bit_val), 32'(seq05[k]));
        end
        readBit(1, bit_val);
        checkOutput("p1_new_bit0", 32'(bit_val), 32'd0);
        readBit(1, bit_val);
        checkOutput("p1_new_bit1", 32'(bit_val), 32'd0);
        readBit(1, bit_val);
        checkOutput("p1_new_bit2", 32'(bit_val), 32'd1);

        $display("[TB] read completing while strobe is high");
        latchPads(live);
        for (int k = 0; k < 3; k++) begin
            readBit(0, bit_val);
        end
        rd[0] = 1'b1;
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        strobe = 1'b1;
        @(negedge clk);
        checkOutput("coincident_live", 32'(data[0]), 32'd1);
        @(posedge clk);
        #1 strobe = 1'b0;
        @(negedge clk);
        checkOutput("coincident_no_shift", 32'(data[0]), 32'd1);
        @(posedge clk);
        #1;
        readBit(0, bit_val);
        checkOutput("coincident_bit0", 32'(bit_val), 32'd1);
        readBit(0, bit_val);
        checkOutput("coincident_bit1", 32'(bit_val), 32'd0);
        checkOutput("pre_reset_data0", 32'(data[0]), 32'd1);

        $display("[TB] async reset mid-shift");
        rst_n = 1'b0;
        #1;
        checkOutput("rst_shift_data", 32'(data), 32'd0);
        checkOutput("rst_shift_btns0", 32'(btns0), 32'h00);
        checkOutput("rst_shift_btns1", 32'(btns1), 32'h00);
        checkOutput("rst_shift_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_shift_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int f = 1; f <= 4; f++) begin
            applyStimulus();
        end
        checkOutput("second_run_cnt4", 32'(frame_cnt), 32'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_frame4_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] held with en low, then released");
        for (int f = 1; f <= 7; f++) begin
            applyStimulus();
        end
        checkOutput("en_low_cnt", 32'(frame_cnt), 32'd7);
        checkOutput("en_low_btns0", 32'(btns0), 32'h00);
        checkOutput("en_low_btns1", 32'(btns1), 32'h00);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("en_rise_not_yet", 32'(btns0), 32'h00);
        @(posedge clk);
        @(negedge clk);
        checkOutput("en_rise_apply_btns0", 32'(btns0), 32'h04);
        checkOutput("en_rise_apply_btns1", 32'(btns1), 32'h00);
        checkOutput("en_rise_cnt", 32'(frame_cnt), 32'd7);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("late_entry_btns0", 32'(btns0), 32'h01);
        checkOutput("late_entry_btns1", 32'(btns1), 32'h80);
        applyStimulus();
        checkOutput("replay_cnt8", 32'(frame_cnt), 32'd8);
        checkOutput("replay_btns0", 32'(btns0), 32'h05);
        checkOutput("replay_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
